ysyx_23060236_ifu: RTL and testbench
====================================

# ysyx_23060236_ifu

Instruction fetch unit: owns the architectural fetch PC and queries the branch target buffer combinationally for the predicted next PC. It issues one AXI-style read per instruction to the instruction memory/cache and hands {inst, pc, predicted next PC} to the decode stage over a valid/ready handshake. It sits directly upstream of the IDU, is the sole reader of the BTB prediction port, and accepts redirects from the EXU on misprediction.

## Interface
- RESET_PC, 32'h3000_0000, first fetch address after reset
- ADDR_W, 32, PC / address width
- DATA_W, 32, instruction width
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low: state reset on any posedge where reset==0
- btb_araddr  out  32  current fetch PC, driven combinationally from the PC register
- btb_rdata  in  32  predicted next PC for btb_araddr (BTB hit target or PC+4)
- ifu_arvalid / ifu_arready  out/in  1  read-address handshake
- ifu_araddr  out  32  fetch address; equals PC register
- ifu_rvalid / ifu_rready  in/out  1  read-data handshake
- ifu_rdata  in  32  fetched instruction
- ifu_rresp  in  2  response; nonzero = access fault
- ifu_valid / idu_ready  out/in  1  output handshake to decode
- inst, pc, pred_npc  out  32 each  registered instruction, its PC, BTB prediction captured at AR handshake
- access_fault  out  1  registered: rresp!=0 for this fetch
- redirect_valid  in  1  EXU mispredict/trap redirect, single-cycle pulse
- redirect_pc  in  32  new fetch PC

## Operation
- FSM states: REQ (arvalid=1), WAIT (rready=1), HOLD (ifu_valid=1).
- REQ: araddr=PC, held stable until arready. On arready: latch pred_npc<=btb_rdata, go WAIT.
- WAIT: on rvalid: if kill==0, latch inst<=rdata, pc<=PC, access_fault<=(rresp!=0), go HOLD; if kill==1, discard data, clear kill, go REQ.
- HOLD: outputs stable while ifu_valid & !idu_ready. On idu_ready: PC<=pred_npc, go REQ.
- Redirect (priority over all same-cycle events):
  - REQ, arready==0: PC address must stay stable, so request continues; store redirect_pc in pend_pc, set kill; response dropped, next REQ uses pend_pc.
  - REQ with arready same cycle, or WAIT: set kill, PC<=redirect_pc; response dropped, then REQ at redirect_pc. Redirect coinciding with rvalid in WAIT: data dropped, go REQ directly.
  - HOLD: drop held instruction (ifu_valid deasserts next cycle even if idu_ready==1 this cycle; IDU flushes on the same redirect), PC<=redirect_pc, go REQ.
- Repeated redirects while kill set: latest redirect_pc wins; still only one response dropped.
- Exactly one outstanding read at any time; arvalid never asserted in WAIT/HOLD.
- Fault fetches are forwarded normally with access_fault=1; IFU does not stop.

## Timing
- Reset values: state=REQ, PC=RESET_PC, kill=0, ifu_valid=0, inst=0, pc=0, pred_npc=0, access_fault=0, rready=0; ifu_arvalid=1 on the first cycle after reset release with araddr=RESET_PC.
- Best case per instruction, 3 cycles: t AR handshake; t+1 rvalid; t+2 ifu_valid & idu_ready; t+3 next arvalid at pred_npc.
- Outputs to IDU are registered, with no combinational path from rdata/rvalid. btb_araddr→btb_rdata is the only combinational input path used, and it is sampled only at AR handshake.
- Redirect latency: first arvalid at redirect_pc no later than 1 cycle after the squashed response returns (WAIT), or the next cycle (HOLD).
- PC arithmetic is done in the BTB (PC+4 on miss, 32-bit wrap); IFU adds nothing.
- Reset asserted mid-transaction: state returns to REQ at RESET_PC; memory side is reset in the same cycle, so no stale response is expected.

## Structure
- Shared defines package: state encodings (REQ/WAIT/HOLD), RESP_OKAY=2'b00, default RESET_PC.
- Single module with no sub-module; FSM, PC/kill/pend_pc registers and output register in one file.

## Test plan
- Reset release, memory arready=1 and rvalid 1 cycle later returning 32'h0000_0013, BTB miss → araddr 30000000, ifu_valid at cycle 2 with pc=30000000, pred_npc=30000004; next araddr 30000004.
- BTB hit at 30000008→30000100, idu_ready=1 → fetch after 30000008 is at 30000100, pred_npc output 30000100.
- Redirect to 30000200 during WAIT, rvalid 4 cycles later → response discarded, no ifu_valid, next araddr 30000200.
- Redirect in REQ with arready held low 3 cycles → araddr stays at old PC until handshake, response dropped, then araddr=redirect_pc.
- idu_ready low 5 cycles in HOLD → inst/pc/pred_npc stable, no new arvalid; redirect coinciding with idu_ready → ifu_valid drops, PC=redirect_pc.
- rresp=2'b10 → access_fault=1 with that pc; following fetch proceeds, access_fault=0.

Source files
------------

// File: rtl/ysyx_23060236_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, response
// codes and the default reset fetch address.
package ysyx_23060236_ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

  // Any non-OKAY read response is reported to decode as an access fault.
  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_23060236_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one read per instruction,
// captures the BTB prediction at the address handshake and presents
// {inst, pc, pred_npc, access_fault} to decode over valid/ready.
//
// state | meaning
// ------+-------------------------------------------------------------------
// REQ   | read address presented (arvalid=1); address held until arready
// WAIT  | one read outstanding (rready=1); response dropped if kill is set
// HOLD  | instruction presented to decode (ifu_valid=1) until idu_ready
module ysyx_23060236_ifu
  import ysyx_23060236_ifu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,

  output logic [ADDR_W-1:0] btb_araddr,
  input  logic [ADDR_W-1:0] btb_rdata,

  output logic              ifu_arvalid,
  input  logic              ifu_arready,
  output logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_rvalid,
  output logic              ifu_rready,
  input  logic [DATA_W-1:0] ifu_rdata,
  input  logic [1:0]        ifu_rresp,

  output logic              ifu_valid,
  input  logic              idu_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pred_npc,
  output logic              access_fault,

  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  ifu_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;        // architectural fetch PC
  logic [ADDR_W-1:0] redir_pc_q;  // latest redirect target while a response is being squashed
  logic              kill_q;      // the outstanding / about-to-issue response must be dropped
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [ADDR_W-1:0] pred_q;
  logic              fault_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              valid_q;

  // Fetch FSM: PC, kill tracking, output register and registered handshake flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      redir_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      pc_out_q   <= '0;
      pred_q     <= '0;
      fault_q    <= 1'b0;
      arvalid_q  <= 1'b1;
      rready_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          // The request address must not change before arready, so a redirect
          // here only arms the squash; the new PC is applied once the dropped
          // response returns (or right away if the handshake is this cycle).
          if (redirect_valid) begin
            kill_q     <= 1'b1;
            redir_pc_q <= redirect_pc;
          end
          if (ifu_arready) begin
            pred_q    <= btb_rdata;
            state_q   <= ST_WAIT;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            if (redirect_valid) begin
              pc_q <= redirect_pc;
            end
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc_q       <= redirect_pc;
            redir_pc_q <= redirect_pc;
            if (ifu_rvalid) begin
              // Response arrives with the redirect: drop it and refetch now.
              kill_q    <= 1'b0;
              state_q   <= ST_REQ;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b0;
            end else begin
              kill_q <= 1'b1;
            end
          end else if (ifu_rvalid) begin
            rready_q <= 1'b0;
            if (kill_q) begin
              kill_q    <= 1'b0;
              pc_q      <= redir_pc_q;
              state_q   <= ST_REQ;
              arvalid_q <= 1'b1;
            end else begin
              inst_q   <= ifu_rdata;
              pc_out_q <= pc_q;
              fault_q  <= resp_is_fault(ifu_rresp);
              state_q  <= ST_HOLD;
              valid_q  <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          // A redirect wins over idu_ready: decode flushes on the same pulse.
          if (redirect_valid) begin
            pc_q      <= redirect_pc;
            state_q   <= ST_REQ;
            valid_q   <= 1'b0;
            arvalid_q <= 1'b1;
          end else if (idu_ready) begin
            pc_q      <= pred_q;
            state_q   <= ST_REQ;
            valid_q   <= 1'b0;
            arvalid_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_REQ;
          kill_q    <= 1'b0;
          arvalid_q <= 1'b1;
          rready_q  <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  // Address side reads the PC register directly; BTB lookup uses the same PC.
  always_comb begin
    btb_araddr   = pc_q;
    ifu_araddr   = pc_q;
    ifu_arvalid  = arvalid_q;
    ifu_rready   = rready_q;
    ifu_valid    = valid_q;
    inst         = inst_q;
    pc           = pc_out_q;
    pred_npc     = pred_q;
    access_fault = fault_q;
  end

endmodule

// File: tb/tb_ysyx_23060236_ifu.sv
// Bench for the fetch unit: directed vector table, hand-written redirect
// sequences, then randomized traffic against a program-order reference.
module tb_ysyx_23060236_ifu;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] btb_araddr, btb_rdata;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_araddr;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_valid, idu_ready;
  logic [31:0] inst, pc, pred_npc;
  logic        access_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_23060236_ifu dut (
    .clock(clock), .reset(reset),
    .btb_araddr(btb_araddr), .btb_rdata(btb_rdata),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp),
    .ifu_valid(ifu_valid), .idu_ready(idu_ready),
    .inst(inst), .pc(pc), .pred_npc(pred_npc), .access_fault(access_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // BTB model: one fixed hit, a pattern of hashed hits, otherwise PC+4.
  function automatic logic [31:0] btb_fn(input logic [31:0] a);
    if (a == 32'h3000_0008) return 32'h3000_0100;
    if (a[6:2] == 5'h1f)    return {a[31:12], a[11:0] ^ 12'h5a0};
    return a + 32'd4;
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [1:0] flt_fn(input logic [31:0] a);
    if (a[6:2] == 5'h0d) return 2'b11;
    if (a[6:2] == 5'h12) return 2'b10;
    return 2'b00;
  endfunction

  always_comb btb_rdata = btb_fn(btb_araddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  typedef struct {
    int unsigned ar_dly;
    int unsigned r_dly;
    int unsigned rdy_dly;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_pc;
    logic [31:0] exp_pred;
    logic        exp_fault;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] pr);
    vec_t v;
    v = '{0, 0, 0, 32'h0000_0013, 2'b00, p, pr, 1'b0};
    return v;
  endfunction

  // One complete fetch from REQ to the next REQ, cycle-exact checks throughout.
  task automatic fetch_vec(input vec_t v);
    chk("req_arvalid", ifu_arvalid, 1);
    chk("req_araddr", ifu_araddr, v.exp_pc);
    chk("req_btb_araddr", btb_araddr, v.exp_pc);
    ifu_arready = 1'b0;
    for (int i = 0; i < int'(v.ar_dly); i++) begin
      tick();
      chk("ar_stall_arvalid", ifu_arvalid, 1);
      chk("ar_stall_araddr", ifu_araddr, v.exp_pc);
    end
    ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
    chk("wait_arvalid", ifu_arvalid, 0);
    chk("wait_rready", ifu_rready, 1);
    for (int i = 0; i < int'(v.r_dly); i++) begin
      tick();
      chk("wait_novalid", ifu_valid, 0);
    end
    ifu_rvalid = 1'b1;
    ifu_rdata  = v.rdata;
    ifu_rresp  = v.rresp;
    tick();
    ifu_rvalid = 1'b0;
    ifu_rdata  = 32'hdead_beef;
    ifu_rresp  = 2'b00;
    for (int i = 0; i <= int'(v.rdy_dly); i++) begin
      if (i != 0) tick();
      chk("hold_valid", ifu_valid, 1);
      chk("hold_inst", inst, v.rdata);
      chk("hold_pc", pc, v.exp_pc);
      chk("hold_pred", pred_npc, v.exp_pred);
      chk("hold_fault", access_fault, v.exp_fault);
      chk("hold_noar", ifu_arvalid, 0);
    end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    chk("next_novalid", ifu_valid, 0);
    chk("next_arvalid", ifu_arvalid, 1);
    chk("next_araddr", ifu_araddr, v.exp_pred);
  endtask

  vec_t vecs[6];

  // Random-phase reference state
  logic [31:0] exp_pc, out_addr, prev_addr;
  bit          outst, prev_stall;
  int unsigned dly;
  int          n_del;

  initial begin
    reset = 1'b0;
    ifu_arready = 0; ifu_rvalid = 0; ifu_rdata = 0; ifu_rresp = 0;
    idu_ready = 0; redirect_valid = 0; redirect_pc = 0;

    vecs[0] = '{0, 0, 0, 32'h0000_0013, 2'b00, 32'h3000_0000, 32'h3000_0004, 1'b0};
    vecs[1] = '{2, 1, 0, 32'h0010_0093, 2'b00, 32'h3000_0004, 32'h3000_0008, 1'b0};
    vecs[2] = '{0, 2, 0, 32'h0000_006f, 2'b00, 32'h3000_0008, 32'h3000_0100, 1'b0};
    vecs[3] = '{1, 0, 5, 32'h00a0_0513, 2'b00, 32'h3000_0100, 32'h3000_0104, 1'b0};
    vecs[4] = '{0, 0, 1, 32'hbad0_0001, 2'b10, 32'h3000_0104, 32'h3000_0108, 1'b1};
    vecs[5] = '{0, 1, 0, 32'h0000_0073, 2'b00, 32'h3000_0108, 32'h3000_010c, 1'b0};

    repeat (3) tick();
    chk("rst_valid", ifu_valid, 0);
    chk("rst_rready", ifu_rready, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pred", pred_npc, 0);
    chk("rst_fault", access_fault, 0);
    chk("rst_araddr", ifu_araddr, RESET_PC);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) fetch_vec(vecs[i]);

    // Redirect while waiting; squashed response returns 4 cycles later.
    ifu_arready = 1; tick(); ifu_arready = 0;
    redirect_valid = 1; redirect_pc = 32'h3000_0200; tick(); redirect_valid = 0;
    repeat (3) begin
      tick();
      chk("wredir_novalid", ifu_valid, 0);
      chk("wredir_noar", ifu_arvalid, 0);
    end
    ifu_rvalid = 1; tick(); ifu_rvalid = 0;
    chk("wredir_drop", ifu_valid, 0);
    chk("wredir_arvalid", ifu_arvalid, 1);
    chk("wredir_araddr", ifu_araddr, 32'h3000_0200);
    fetch_vec(mk(32'h3000_0200, 32'h3000_0204));

    // Redirect in REQ with arready held low for 3 cycles.
    redirect_valid = 1; redirect_pc = 32'h3000_0300; tick(); redirect_valid = 0;
    chk("rredir_arvalid", ifu_arvalid, 1);
    chk("rredir_keep", ifu_araddr, 32'h3000_0204);
    repeat (2) begin
      tick();
      chk("rredir_keep", ifu_araddr, 32'h3000_0204);
    end
    ifu_arready = 1; tick(); ifu_arready = 0;
    chk("rredir_rready", ifu_rready, 1);
    ifu_rvalid = 1; tick(); ifu_rvalid = 0;
    chk("rredir_drop", ifu_valid, 0);
    chk("rredir_araddr", ifu_araddr, 32'h3000_0300);
    fetch_vec(mk(32'h3000_0300, 32'h3000_0304));

    // Redirect coinciding with idu_ready in HOLD.
    ifu_arready = 1; tick(); ifu_arready = 0;
    ifu_rvalid = 1; tick(); ifu_rvalid = 0;
    chk("hredir_valid", ifu_valid, 1);
    chk("hredir_pc", pc, 32'h3000_0304);
    idu_ready = 1; redirect_valid = 1; redirect_pc = 32'h3000_0400; tick();
    idu_ready = 0; redirect_valid = 0;
    chk("hredir_novalid", ifu_valid, 0);
    chk("hredir_arvalid", ifu_arvalid, 1);
    chk("hredir_araddr", ifu_araddr, 32'h3000_0400);
    fetch_vec(mk(32'h3000_0400, 32'h3000_0404));

    // Redirect on the same cycle as rvalid in WAIT.
    ifu_arready = 1; tick(); ifu_arready = 0;
    ifu_rvalid = 1; redirect_valid = 1; redirect_pc = 32'h3000_0500; tick();
    ifu_rvalid = 0; redirect_valid = 0;
    chk("rvredir_novalid", ifu_valid, 0);
    chk("rvredir_arvalid", ifu_arvalid, 1);
    chk("rvredir_araddr", ifu_araddr, 32'h3000_0500);
    fetch_vec(mk(32'h3000_0500, 32'h3000_0504));

    // Two redirects while kill is set: latest wins, one response dropped.
    ifu_arready = 1; tick(); ifu_arready = 0;
    redirect_valid = 1; redirect_pc = 32'h3000_0600; tick();
    redirect_pc = 32'h3000_0700; tick(); redirect_valid = 0;
    ifu_rvalid = 1; tick(); ifu_rvalid = 0;
    chk("dredir_novalid", ifu_valid, 0);
    chk("dredir_araddr", ifu_araddr, 32'h3000_0700);
    fetch_vec(mk(32'h3000_0700, 32'h3000_0704));

    // Reset in the middle of a transaction.
    ifu_arready = 1; tick(); ifu_arready = 0;
    reset = 0; tick(); reset = 1;
    chk("mrst_arvalid", ifu_arvalid, 1);
    chk("mrst_araddr", ifu_araddr, RESET_PC);
    chk("mrst_rready", ifu_rready, 0);
    chk("mrst_valid", ifu_valid, 0);
    chk("mrst_pc", pc, 0);

    // Random traffic: delivered stream must follow predicted flow from the
    // last redirect, with data/fault/prediction consistent with the models.
    exp_pc = RESET_PC; outst = 0; prev_stall = 0; dly = 0; n_del = 0;
    prev_addr = 0; out_addr = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      chk("one_phase", 32'(int'(ifu_arvalid) + int'(ifu_rready) + int'(ifu_valid)), 1);
      if (prev_stall) begin
        chk("rnd_ar_hold", ifu_arvalid, 1);
        chk("rnd_ar_stable", ifu_araddr, prev_addr);
      end
      if (outst) chk("rnd_rready_outst", ifu_rready, 1);

      ifu_arready    = ($urandom_range(0, 2) != 0);
      idu_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 32'h3000_0000 | (32'($urandom_range(0, 1023)) << 2);
      if (outst && dly == 0) begin
        ifu_rvalid = 1; ifu_rdata = mem_fn(out_addr); ifu_rresp = flt_fn(out_addr);
      end else begin
        ifu_rvalid = 0; ifu_rdata = $urandom; ifu_rresp = 2'b00;
      end

      if (ifu_valid && idu_ready && !redirect_valid) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_inst", inst, mem_fn(pc));
        chk("rnd_pred", pred_npc, btb_fn(pc));
        chk("rnd_fault", access_fault, 32'(flt_fn(pc) != 2'b00));
        exp_pc = pred_npc;
        n_del++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      if (ifu_rvalid && ifu_rready) outst = 0;
      else if (outst && dly > 0) dly--;
      if (ifu_arvalid && ifu_arready) begin
        chk("rnd_single_outst", 32'(outst), 0);
        outst = 1; out_addr = ifu_araddr; dly = $urandom_range(0, 3);
      end
      prev_stall = ifu_arvalid && !ifu_arready;
      prev_addr  = ifu_araddr;
    end
    chk("rnd_progress", 32'(n_del > 150), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
